// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared command, ALU opcode and FSM state definitions for alu_accum_ctrl
package alu_ctrl_pkg;

  localparam int CMD_W  = 3;
  localparam int DATA_W = 4;
  localparam int OP_W   = 2;

  localparam logic [CMD_W-1:0] CMD_ADD      = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SUB      = 3'd1;
  localparam logic [CMD_W-1:0] CMD_AND      = 3'd2;
  localparam logic [CMD_W-1:0] CMD_OR       = 3'd3;
  localparam logic [CMD_W-1:0] CMD_LOAD     = 3'd4;
  localparam logic [CMD_W-1:0] CMD_CLEAR    = 3'd5;
  localparam logic [CMD_W-1:0] CMD_PASS     = 3'd6;
  localparam logic [CMD_W-1:0] CMD_PASS_ALT = 3'd7;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_alu_cmd(input logic [CMD_W-1:0] cmd);
    return !cmd[2];
  endfunction

  function automatic logic [OP_W-1:0] alu_op_of(input logic [CMD_W-1:0] cmd);
    case (cmd)
      CMD_ADD: return OP_ADD;
      CMD_SUB: return OP_SUB;
      CMD_AND: return OP_AND;
      CMD_OR:  return OP_OR;
      default: return cmd[1:0];
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - parameterised synchronous FIFO; occupancy counter separates full from empty
module cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/alu_accum_ctrl.sv
// rtl/alu_accum_ctrl.sv - accumulator issue/writeback stage for a 4-bit ALU; ALU_CTRL_CARRY_EN adds out_carry
module alu_accum_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef ALU_CTRL_CARRY_EN
  output logic              out_carry,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero
);

  localparam int ENTRY_W = CMD_W + DATA_W;

  state_e              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [CMD_W-1:0]    cmd_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_zero_q;
  logic [DATA_W-1:0]   result_d;
  logic                zero_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [CMD_W-1:0]    head_cmd;
  logic [DATA_W-1:0]   head_imm;

  assign head_cmd = fifo_head[ENTRY_W-1:DATA_W];
  assign head_imm = fifo_head[DATA_W-1:0];
  assign in_ready = !fifo_full;

  // Pop whenever the FSM is about to issue: from IDLE, or on a RESP handshake.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == ST_IDLE) || (state_q == ST_RESP && out_valid_q && out_ready));

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_valid),
    .push_data_i ({in_cmd, in_imm}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Non-ALU commands resolve locally from the registered operands.
  always_comb begin
    result_d = alu_result;
    zero_d   = alu_zero;
    if (!is_alu_cmd(cmd_q)) begin
      case (cmd_q)
        CMD_LOAD:               result_d = alu_b_q;
        CMD_CLEAR:              result_d = '0;
        CMD_PASS, CMD_PASS_ALT: result_d = alu_a_q;
        default:                result_d = alu_a_q;
      endcase
      zero_d = (result_d == '0);
    end
  end

`ifdef ALU_CTRL_CARRY_EN
  logic              carry_q;
  logic              carry_d;
  logic [DATA_W:0]   sum_ext;

  assign sum_ext = {1'b0, alu_a_q} + {1'b0, alu_b_q};

  always_comb begin
    carry_d = 1'b0;
    if (cmd_q == CMD_ADD)      carry_d = sum_ext[DATA_W];
    else if (cmd_q == CMD_SUB) carry_d = (alu_a_q < alu_b_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  carry_q <= 1'b0;
    else if (state_q == ST_ISSUE) carry_q <= carry_d;
  end

  assign out_carry = carry_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      cmd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a_q  <= acc_q;
            alu_b_q  <= head_imm;
            alu_op_q <= alu_op_of(head_cmd);
            cmd_q    <= head_cmd;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          acc_q       <= result_d;
          out_data_q  <= result_d;
          out_zero_q  <= zero_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              alu_a_q  <= acc_q;
              alu_b_q  <= head_imm;
              alu_op_q <= alu_op_of(head_cmd);
              cmd_q    <= head_cmd;
              state_q  <= ST_ISSUE;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_zero   = out_zero_q;

endmodule
